// File: rtl/codiq_pkg.sv
// Shared types and constants for the O-QPSK IQ coder/decoder pair.
package codiq_pkg;
  localparam int IQ_W      = 4;
  localparam int ACC_W     = 9;
  localparam int SPC_DEF   = 25;
  localparam int E_ON_DEF  = 4;
  localparam int E_OFF_DEF = 40;

  // Differential reference of the Q rail at the start of every burst.
  localparam logic Q_REF_SIGN = 1'b1;

  typedef logic signed [IQ_W-1:0]  iq_sample_t;
  typedef logic signed [ACC_W-1:0] iq_acc_t;
  typedef enum logic {IDLE, TRACK} dec_state_t;

  function automatic logic [ACC_W-1:0] acc_mag(input iq_acc_t x);
    iq_acc_t m;
    m = (x < 0) ? -x : x;
    return unsigned'(m);
  endfunction

  // |I|+|Q| with one guard bit so that |-8| is representable.
  function automatic logic [IQ_W:0] iq_energy(input iq_sample_t i, input iq_sample_t q);
    logic signed [IQ_W:0] ie;
    logic signed [IQ_W:0] qe;
    ie = {i[IQ_W-1], i};
    qe = {q[IQ_W-1], q};
    ie = (ie < 0) ? -ie : ie;
    qe = (qe < 0) ? -qe : qe;
    return unsigned'(ie) + unsigned'(qe);
  endfunction
endpackage

// File: rtl/decodeur_iq_if.sv
// Sample input and decoded-bit output bundle of the IQ chip decoder.
interface decodeur_iq_if;
  import codiq_pkg::*;

  logic       en_adc;
  iq_sample_t IBB_in;
  iq_sample_t QBB_in;
  logic       b_out;
  logic       b_valid;
  logic       locked;

  modport master (output en_adc, IBB_in, QBB_in, input b_out, b_valid, locked);
  modport slave  (input en_adc, IBB_in, QBB_in, output b_out, b_valid, locked);
endinterface

// File: rtl/iq_integrator.sv
// Integrate-and-dump accumulator for one rail; clr has priority over add.
module iq_integrator
  import codiq_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       clr,
  input  logic       add,
  input  iq_sample_t sample,
  output iq_acc_t    sum
);
  iq_acc_t sum_d;
  iq_acc_t sum_q;

  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (add) begin
      sum_d = sum_q + iq_acc_t'(sample);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;
endmodule

// File: rtl/decodeur_iq.sv
// O-QPSK chip decoder: energy trigger, per-chip rail integration and
// differential bit recovery with a registered one-cycle valid strobe.
module decodeur_iq
  import codiq_pkg::*;
#(
  parameter int SPC   = SPC_DEF,
  parameter int E_ON  = E_ON_DEF,
  parameter int E_OFF = E_OFF_DEF
) (
  input  logic          clk,
  input  logic          resetn,
  decodeur_iq_if.slave  bus
);
  localparam int                CNT_W    = $clog2(SPC);
  localparam int                EN_W     = IQ_W + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SPC - 1);
  localparam logic [EN_W-1:0]   E_ON_V   = EN_W'(E_ON);
  localparam logic [ACC_W-1:0]  E_OFF_V  = ACC_W'(E_OFF);

  dec_state_t       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             rail_d, rail_q;    // 0: I rail, 1: Q rail
  logic             first_d, first_q;  // chip 0 of the burst still pending
  logic             b_d, b_q;
  logic             vld_d, vld_q;
  logic             si_d, si_q;
  logic             sq_d, sq_q;

  iq_sample_t smp_i, smp_q, act_smp;
  iq_acc_t    sum_i, sum_q, act_sum, chip_sum;
  logic       s_dec, same;
  logic       add_i, add_q, clr_acc;

  assign smp_i = bus.IBB_in;
  assign smp_q = bus.QBB_in;

  iq_integrator u_int_i (
    .clk(clk), .resetn(resetn), .clr(clr_acc), .add(add_i), .sample(smp_i), .sum(sum_i)
  );
  iq_integrator u_int_q (
    .clk(clk), .resetn(resetn), .clr(clr_acc), .add(add_q), .sample(smp_q), .sum(sum_q)
  );

  // The decision includes the chip's last sample, which never lands in the accumulator.
  assign act_smp  = rail_q ? smp_q : smp_i;
  assign act_sum  = rail_q ? sum_q : sum_i;
  assign chip_sum = act_sum + iq_acc_t'(act_smp);
  assign s_dec    = ~chip_sum[ACC_W-1];
  assign same     = s_dec ~^ (rail_q ? sq_q : si_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rail_d  = rail_q;
    first_d = first_q;
    b_d     = b_q;
    vld_d   = 1'b0;
    si_d    = si_q;
    sq_d    = sq_q;
    add_i   = 1'b0;
    add_q   = 1'b0;
    clr_acc = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.en_adc && (iq_energy(smp_i, smp_q) >= E_ON_V)) begin
          state_d = TRACK;
          cnt_d   = CNT_W'(1);
          rail_d  = 1'b0;
          first_d = 1'b1;
          sq_d    = Q_REF_SIGN;
          add_i   = 1'b1;
        end
      end
      TRACK: begin
        if (bus.en_adc) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            clr_acc = 1'b1;
            if (acc_mag(chip_sum) < E_OFF_V) begin
              state_d = IDLE;
              rail_d  = 1'b0;
            end else begin
              vld_d   = 1'b1;
              rail_d  = ~rail_q;
              first_d = 1'b0;
              b_d     = first_q ? s_dec : (b_q ^ same);
              if (rail_q) sq_d = s_dec;
              else        si_d = s_dec;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
            add_i = ~rail_q;
            add_q = rail_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rail_q  <= 1'b0;
      first_q <= 1'b0;
      b_q     <= 1'b0;
      vld_q   <= 1'b0;
      si_q    <= 1'b0;
      sq_q    <= Q_REF_SIGN;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rail_q  <= rail_d;
      first_q <= first_d;
      b_q     <= b_d;
      vld_q   <= vld_d;
      si_q    <= si_d;
      sq_q    <= sq_d;
    end
  end

  assign bus.b_out   = b_q;
  assign bus.b_valid = vld_q;
  assign bus.locked  = (state_q == TRACK);
endmodule

// File: tb/tb_decodeur_iq.sv
// Directed bench for decodeur_iq: two instances (E_OFF=40 and E_OFF=0) fed
// the same samples, checked every cycle against a chip-level model.
module tb_decodeur_iq;
  import codiq_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  decodeur_iq_if bus0 ();
  decodeur_iq_if bus1 ();

  decodeur_iq #(.SPC(25), .E_ON(4), .E_OFF(40)) dut0 (.clk(clk), .resetn(resetn), .bus(bus0));
  decodeur_iq #(.SPC(25), .E_ON(4), .E_OFF(0))  dut1 (.clk(clk), .resetn(resetn), .bus(bus1));

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic       cur_rst = 1'b1;
  logic       cur_en  = 1'b0;
  iq_sample_t cur_i   = '0;
  iq_sample_t cur_q   = '0;

  // Chip-level model state, one slot per instance.
  logic m_trk[2];
  int   m_n[2];
  int   m_sum[2];
  int   m_k[2];
  logic m_b[2];
  logic m_si[2];
  logic m_sq[2];
  logic e_v[2];
  logic e_b[2];
  logic e_l[2];

  int   p_cyc[2][$];
  logic p_bit[2][$];
  int   l_rise[2];
  logic prev_l[2];

  task automatic chk(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic void model_step(input int d, input int eoff);
    int   smp;
    logic s;
    if (cur_rst) begin
      m_trk[d] = 1'b0; m_n[d] = 0; m_sum[d] = 0; m_k[d] = 0;
      m_b[d] = 1'b0; m_si[d] = 1'b0; m_sq[d] = 1'b1;
      e_v[d] = 1'b0; e_b[d] = 1'b0; e_l[d] = 1'b0;
      return;
    end
    e_v[d] = 1'b0;
    if (cur_en) begin
      if (!m_trk[d]) begin
        if (iabs(int'(cur_i)) + iabs(int'(cur_q)) >= 4) begin
          m_trk[d] = 1'b1; m_n[d] = 1; m_sum[d] = int'(cur_i); m_k[d] = 0; m_sq[d] = 1'b1;
        end
      end else begin
        smp = (m_k[d] % 2 == 0) ? int'(cur_i) : int'(cur_q);
        m_sum[d] += smp;
        m_n[d]++;
        if (m_n[d] == 25) begin
          if (iabs(m_sum[d]) < eoff) begin
            m_trk[d] = 1'b0;
          end else begin
            s = (m_sum[d] >= 0);
            if (m_k[d] == 0) m_b[d] = s;
            else if (m_k[d] % 2 == 0) m_b[d] = m_b[d] ^ (s == m_si[d]);
            else m_b[d] = m_b[d] ^ (s == m_sq[d]);
            if (m_k[d] % 2 == 0) m_si[d] = s; else m_sq[d] = s;
            e_v[d] = 1'b1;
            e_b[d] = m_b[d];
            m_k[d]++;
          end
          m_n[d] = 0;
          m_sum[d] = 0;
        end
      end
    end
    e_l[d] = m_trk[d];
  endfunction

  task automatic cmp(input int d, input logic v, input logic b, input logic l);
    chk($sformatf("cyc%0d dut%0d b_valid", cyc, d), v, e_v[d]);
    chk($sformatf("cyc%0d dut%0d b_out", cyc, d), b, e_b[d]);
    chk($sformatf("cyc%0d dut%0d locked", cyc, d), l, e_l[d]);
    if (v === 1'b1) begin
      p_cyc[d].push_back(cyc);
      p_bit[d].push_back(b);
    end
    if (l === 1'b1 && prev_l[d] !== 1'b1) l_rise[d] = cyc;
    prev_l[d] = l;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      model_step(0, 40);
      model_step(1, 0);
      cmp(0, bus0.b_valid, bus0.b_out, bus0.locked);
      cmp(1, bus1.b_valid, bus1.b_out, bus1.locked);
    end
  end

  task automatic step(input logic en, input iq_sample_t i, input iq_sample_t q);
    @(negedge clk);
    resetn = 1'b1;
    cur_rst = 1'b0;
    bus0.en_adc = en; bus0.IBB_in = i; bus0.QBB_in = q;
    bus1.en_adc = en; bus1.IBB_in = i; bus1.QBB_in = q;
    cur_en = en; cur_i = i; cur_q = q;
  endtask

  task automatic do_reset(input int ncyc, input logic imm);
    @(negedge clk);
    resetn = 1'b0;
    cur_rst = 1'b1;
    bus0.en_adc = 1'b0; bus1.en_adc = 1'b0; cur_en = 1'b0;
    #1;
    if (imm) begin
      chk("async reset b_valid", bus0.b_valid, 1'b0);
      chk("async reset locked", bus0.locked, 1'b0);
      chk("async reset b_out", bus0.b_out, 1'b0);
    end
    repeat (ncyc - 1) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      p_cyc[d].delete();
      p_bit[d].delete();
      l_rise[d] = 0;
    end
  endtask

  // Coder model: chip 0 carries b0, later chips flip relative to the last sign on their rail.
  task automatic send_burst(input logic [0:7] bits, input int nb, input int st_chip,
                            input int st_len, input int cut_chip, input int cut_n);
    logic       s_i, s_q, s;
    iq_sample_t v;
    s_i = 1'b0;
    s_q = 1'b1;
    for (int k = 0; k < nb; k++) begin
      if (k == 0)          s = bits[0];
      else if (k % 2 == 1) s = s_q ~^ (bits[k] ^ bits[k-1]);
      else                 s = s_i ~^ (bits[k] ^ bits[k-1]);
      if (k % 2 == 1) s_q = s; else s_i = s;
      v = s ? 4'sd5 : -4'sd5;
      for (int n = 0; n < 25; n++) begin
        if (k == cut_chip && n == cut_n) return;
        if (k == st_chip && n == 12) repeat (st_len) step(1'b0, '0, '0);
        if (k % 2 == 0) step(1'b1, v, -v);
        else            step(1'b1, -v, v);
      end
    end
  endtask

  task automatic check_pulses(input int d, input logic [0:7] exp, input int nb, input int stall_idx);
    chk_int($sformatf("dut%0d pulse count", d), p_cyc[d].size(), nb);
    for (int j = 0; j < nb && j < p_cyc[d].size(); j++) begin
      chk($sformatf("dut%0d bit%0d", d, j), p_bit[d][j], exp[j]);
      if (j == 0) chk_int($sformatf("dut%0d first latency", d), p_cyc[d][0] - l_rise[d], 24);
      else chk_int($sformatf("dut%0d spacing%0d", d, j), p_cyc[d][j] - p_cyc[d][j-1],
                   (j == stall_idx) ? 68 : 25);
    end
  endtask

  initial begin
    iq_sample_t ni, nq;
    bus0.en_adc = 1'b0; bus0.IBB_in = '0; bus0.QBB_in = '0;
    bus1.en_adc = 1'b0; bus1.IBB_in = '0; bus1.QBB_in = '0;
    do_reset(3, 1'b1);

    // Loopback
    send_burst(8'b10110010, 8, -1, 0, -1, 0);
    repeat (5) step(1'b0, '0, '0);
    check_pulses(0, 8'b10110010, 8, -1);
    check_pulses(1, 8'b10110010, 8, -1);
    chk("loopback locked held", bus0.locked, 1'b1);

    // Stall of 43 cycles at sample 12 of chip 3
    do_reset(2, 1'b0);
    send_burst(8'b10110010, 8, 3, 43, -1, 0);
    repeat (5) step(1'b0, '0, '0);
    check_pulses(0, 8'b10110010, 8, 3);

    // End of burst: 4 chips then a zero chip
    do_reset(2, 1'b0);
    send_burst(8'b10110010, 4, -1, 0, -1, 0);
    for (int n = 0; n < 25; n++) begin
      step(1'b1, '0, '0);
      @(posedge clk);
      #1;
      if (n == 23) chk("eob locked before last", bus0.locked, 1'b1);
      if (n == 24) chk("eob locked after last", bus0.locked, 1'b0);
    end
    repeat (30) step(1'b0, '0, '0);
    check_pulses(0, 8'b10110010, 4, -1);
    chk_int("eob dut1 pulse count", p_cyc[1].size(), 5);

    // Tie: I sums to zero over chip 0
    do_reset(2, 1'b0);
    for (int n = 0; n < 25; n++) begin
      if (n == 24)         step(1'b1, 4'sd0, 4'sd3);
      else if (n % 2 == 0) step(1'b1, 4'sd1, 4'sd3);
      else                 step(1'b1, -4'sd1, 4'sd3);
    end
    repeat (3) step(1'b0, '0, '0);
    chk_int("tie dut1 pulses", p_bit[1].size(), 1);
    if (p_bit[1].size() > 0) chk("tie dut1 b_out", p_bit[1][0], 1'b1);
    chk_int("tie dut0 pulses", p_bit[0].size(), 0);
    chk("tie dut0 locked", bus0.locked, 1'b0);

    // Reset at sample 10 of chip 2, then a fresh burst
    do_reset(2, 1'b0);
    send_burst(8'b11000000, 4, -1, 0, 2, 10);
    chk_int("pre-reset pulses", p_bit[0].size(), 2);
    do_reset(3, 1'b1);
    send_burst(8'b01100000, 4, -1, 0, -1, 0);
    repeat (3) step(1'b0, '0, '0);
    check_pulses(0, 8'b01100000, 4, -1);

    // Sub-threshold noise, then an exact-threshold trigger
    do_reset(2, 1'b0);
    for (int c = 0; c < 200; c++) begin
      ni = (c % 2 == 1) ? 4'sd1 : -4'sd1;
      nq = (c % 3 == 0) ? 4'sd1 : -4'sd1;
      if (c % 7 == 0)  begin ni = 4'sd2;  nq = -4'sd1; end
      if (c % 11 == 0) begin ni = -4'sd3; nq = 4'sd0;  end
      step(1'b1, ni, nq);
    end
    step(1'b0, '0, '0);
    chk_int("noise pulses", p_bit[0].size(), 0);
    chk("noise locked", bus0.locked, 1'b0);
    chk_int("noise lock rises", l_rise[0], 0);
    step(1'b1, 4'sd2, -4'sd2);
    step(1'b0, '0, '0);
    chk("E_ON boundary locks", bus0.locked, 1'b1);
    do_reset(2, 1'b0);
    step(1'b0, '0, '0);
    step(1'b0, '0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
